// File: rtl/stage_cordic_resolve.sv
// Three-stage resolver: turns a rotated CORDIC vertex offset into a per-pixel hit for circle/square shapes.
// Optional per-frame hit counter enabled by defining CORDIC_RESOLVE_STATS_EN.
module stage_cordic_resolve #(
    parameter logic [8:0] BG_COLOR = 9'h000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [18:0] cord_x,
    input  logic signed [18:0] cord_y,
    input  logic               in_bubble,
    input  logic [8:0]         in_color,
    input  logic [9:0]         in_pixel_x,
    input  logic [9:0]         in_pixel_y,
    input  logic [8:0]         in_ref_point_x,
    input  logic [8:0]         in_ref_point_y,
    input  logic [0:0]         in_form,
    output logic               out_bubble,
    output logic [8:0]         out_color,
    output logic [9:0]         out_pixel_x,
    output logic [9:0]         out_pixel_y,
    output logic [0:0]         out_hit
`ifdef CORDIC_RESOLVE_STATS_EN
    ,
    output logic [15:0]        hit_count
`endif
);

    // Round half up (Q11.8 -> integer) and clamp to +/-255.
    function automatic logic signed [8:0] round_sat(input logic signed [18:0] v);
        logic signed [19:0] sum;
        logic signed [11:0] q;
        sum = 20'(v) + 20'sd128;
        q   = 12'(sum >>> 8);
        if (q > 12'sd255) begin
            return 9'sd255;
        end else if (q < -12'sd255) begin
            return -9'sd255;
        end else begin
            return 9'(q);
        end
    endfunction

    function automatic logic [20:0] abs21(input logic signed [20:0] v);
        return v[20] ? $unsigned(-v) : $unsigned(v);
    endfunction

    logic signed [8:0]  dx_q, dy_q;
    logic signed [10:0] px_q, py_q;
    logic [8:0]         color1_q, color2_q;
    logic [9:0]         pix_x1_q, pix_y1_q, pix_x2_q, pix_y2_q;
    logic               form1_q, form2_q;
    logic               bubble1_q, bubble2_q;
    logic [17:0]        r2_q, r2_d;
    logic [21:0]        c2_q, c2_d;
    logic signed [20:0] dot_q, crs_q, dot_d, crs_d;
    logic signed [17:0] dx18_s, dy18_s;
    logic signed [20:0] dx21_s, dy21_s, px21_s, py21_s;
    logic signed [21:0] px22_s, py22_s;
    logic               hit_s;

    // Bubble flags are the only pipeline state that must be cleared on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble1_q <= 1'b1;
            bubble2_q <= 1'b1;
        end else begin
            bubble1_q <= in_bubble;
            bubble2_q <= bubble1_q;
        end
    end

    // S1: integer vertex offset and pixel offset from the reference point.
    always_ff @(posedge clk) begin
        dx_q     <= round_sat(cord_x);
        dy_q     <= round_sat(cord_y);
        px_q     <= $signed({1'b0, in_pixel_x}) - $signed({2'b00, in_ref_point_x});
        py_q     <= $signed({1'b0, in_pixel_y}) - $signed({2'b00, in_ref_point_y});
        color1_q <= in_color;
        pix_x1_q <= in_pixel_x;
        pix_y1_q <= in_pixel_y;
        form1_q  <= in_form[0];
    end

    // Operands are widened to the exact result width so each sum is exact modulo its width.
    assign dx18_s = 18'(dx_q);
    assign dy18_s = 18'(dy_q);
    assign dx21_s = 21'(dx_q);
    assign dy21_s = 21'(dy_q);
    assign px21_s = 21'(px_q);
    assign py21_s = 21'(py_q);
    assign px22_s = 22'(px_q);
    assign py22_s = 22'(py_q);

    // S2 combinational products.
    always_comb begin
        r2_d  = $unsigned(dx18_s * dx18_s + dy18_s * dy18_s);
        c2_d  = $unsigned(px22_s * px22_s + py22_s * py22_s);
        dot_d = px21_s * dx21_s + py21_s * dy21_s;
        crs_d = py21_s * dx21_s - px21_s * dy21_s;
    end

    // S2: squared radius, squared pixel distance and projections.
    always_ff @(posedge clk) begin
        r2_q     <= r2_d;
        c2_q     <= c2_d;
        dot_q    <= dot_d;
        crs_q    <= crs_d;
        color2_q <= color1_q;
        pix_x2_q <= pix_x1_q;
        pix_y2_q <= pix_y1_q;
        form2_q  <= form1_q;
    end

    // S3 decision; a degenerate square (r2 = 0) only covers its own centre.
    always_comb begin
        hit_s = 1'b0;
        if (!form2_q) begin
            hit_s = (c2_q <= {4'b0000, r2_q});
        end else begin
            hit_s = (abs21(dot_q) <= {3'b000, r2_q}) &&
                    (abs21(crs_q) <= {3'b000, r2_q}) &&
                    ((r2_q != 18'd0) || (c2_q == 22'd0));
        end
    end

    // S3 resolved-pixel outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_bubble <= 1'b1;
            out_hit    <= 1'b0;
            out_color  <= BG_COLOR;
        end else begin
            out_bubble <= bubble2_q;
            out_hit    <= hit_s && !bubble2_q;
            out_color  <= (hit_s && !bubble2_q) ? color2_q : BG_COLOR;
        end
    end

    // S3 pixel coordinates pass through even for bubbles.
    always_ff @(posedge clk) begin
        out_pixel_x <= pix_x2_q;
        out_pixel_y <= pix_y2_q;
    end

`ifdef CORDIC_RESOLVE_STATS_EN
    logic [15:0] hit_count_q;

    // Saturating hit counter, restarted by the frame-origin pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count_q <= 16'd0;
        end else if (!bubble2_q && (pix_x2_q == 10'd0) && (pix_y2_q == 10'd0)) begin
            hit_count_q <= hit_s ? 16'd1 : 16'd0;
        end else if (!bubble2_q && hit_s && (hit_count_q != 16'hFFFF)) begin
            hit_count_q <= hit_count_q + 16'd1;
        end else begin
            hit_count_q <= hit_count_q;
        end
    end

    assign hit_count = hit_count_q;
`endif

endmodule

// File: tb/tb_stage_cordic_resolve.sv
// Scoreboard bench for stage_cordic_resolve: directed vectors with hand-computed hits.
module tb_stage_cordic_resolve;
    localparam logic [8:0] BG = 9'h0A5;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [18:0] cord_x = 19'd0, cord_y = 19'd0;
    logic               in_bubble = 1'b1;
    logic [8:0]         in_color = 9'd0;
    logic [9:0]         in_pixel_x = 10'd0, in_pixel_y = 10'd0;
    logic [8:0]         in_ref_point_x = 9'd0, in_ref_point_y = 9'd0;
    logic [0:0]         in_form = 1'b0;
    logic               out_bubble;
    logic [8:0]         out_color;
    logic [9:0]         out_pixel_x, out_pixel_y;
    logic [0:0]         out_hit;
`ifdef CORDIC_RESOLVE_STATS_EN
    logic [15:0]        hit_count;
`endif

    stage_cordic_resolve #(.BG_COLOR(BG)) dut (
        .clk(clk), .reset(reset), .cord_x(cord_x), .cord_y(cord_y),
        .in_bubble(in_bubble), .in_color(in_color),
        .in_pixel_x(in_pixel_x), .in_pixel_y(in_pixel_y),
        .in_ref_point_x(in_ref_point_x), .in_ref_point_y(in_ref_point_y),
        .in_form(in_form), .out_bubble(out_bubble), .out_color(out_color),
        .out_pixel_x(out_pixel_x), .out_pixel_y(out_pixel_y), .out_hit(out_hit)
`ifdef CORDIC_RESOLVE_STATS_EN
        , .hit_count(hit_count)
`endif
    );

    typedef struct {
        logic       hit;
        logic [8:0] color;
        logic [9:0] x;
        logic [9:0] y;
        int         edge_n;
    } exp_t;

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    logic [8:0] col_ctr = 9'h100;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endfunction

    // Drive one slot now (caller aligns to the falling edge) and record its expected output.
    task automatic drive(input bit bub, input logic [18:0] cx, input logic [18:0] cy,
                         input logic [9:0] x, input logic [9:0] y,
                         input logic [8:0] rx, input logic [8:0] ry,
                         input bit form, input bit hit);
        exp_t e;
        col_ctr        = (col_ctr == 9'h1FF) ? 9'h100 : col_ctr + 9'd1;
        in_bubble      = bub;
        cord_x         = cx;
        cord_y         = cy;
        in_pixel_x     = x;
        in_pixel_y     = y;
        in_ref_point_x = rx;
        in_ref_point_y = ry;
        in_form        = form;
        in_color       = col_ctr;
        if (!bub) begin
            e.hit    = hit;
            e.color  = hit ? col_ctr : BG;
            e.x      = x;
            e.y      = y;
            e.edge_n = cyc + 3;
            sb.push_back(e);
        end
    endtask

    task automatic send(input bit bub, input logic [18:0] cx, input logic [18:0] cy,
                        input logic [9:0] x, input logic [9:0] y,
                        input logic [8:0] rx, input logic [8:0] ry,
                        input bit form, input bit hit);
        @(negedge clk);
        drive(bub, cx, cy, x, y, rx, ry, form, hit);
    endtask

    task automatic drain();
        @(negedge clk);
        in_bubble = 1'b1;
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() > 0) check("drain_timeout", sb.size(), 0);
    endtask

    // Monitor: compare every presented pixel, and check bubble slots are blanked.
    initial begin
        exp_t e;
        wait (mon_en);
        forever begin
            @(posedge clk);
            #1;
            if (out_bubble === 1'b0) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("hit", int'(out_hit), int'(e.hit));
                    check("color", int'(out_color), int'(e.color));
                    check("pixel_x", int'(out_pixel_x), int'(e.x));
                    check("pixel_y", int'(out_pixel_y), int'(e.y));
                    check("latency_edge", cyc, e.edge_n);
                end
            end else begin
                check("bubble_hit", int'(out_hit), 0);
                check("bubble_color", int'(out_color), int'(BG));
            end
        end
    end

    initial begin
        #12 reset = 1'b0;
        #1;
        check("reset_bubble", int'(out_bubble), 1);
        check("reset_hit", int'(out_hit), 0);
        check("reset_color", int'(out_color), int'(BG));
`ifdef CORDIC_RESOLVE_STATS_EN
        check("reset_hit_count", int'(hit_count), 0);
`endif
        mon_en = 1'b1;
        #20;
        @(negedge clk);
        reset = 1'b1;

        // Circle and square around ref (100,100), dx=10 dy=0 -> r2=100.
        send(0, 19'd2560, 19'd0, 10'd106, 10'd108, 9'd100, 9'd100, 0, 1);
        send(0, 19'd2560, 19'd0, 10'd107, 10'd108, 9'd100, 9'd100, 0, 0);
        send(0, 19'd2560, 19'd0, 10'd110, 10'd90,  9'd100, 9'd100, 1, 1);
        send(0, 19'd2560, 19'd0, 10'd111, 10'd100, 9'd100, 9'd100, 1, 0);
        send(0, 19'd2560, 19'd0, 10'd90,  10'd110, 9'd100, 9'd100, 1, 1);
        // dy only: dy=10.
        send(0, 19'd0, 19'd2560, 10'd100, 10'd110, 9'd100, 9'd100, 0, 1);
        send(0, 19'd0, 19'd2560, 10'd110, 10'd110, 9'd100, 9'd100, 1, 1);
        send(0, 19'd0, 19'd2560, 10'd111, 10'd100, 9'd100, 9'd100, 1, 0);
        // Rounding: +2.5 -> 3, -2.5 -> -2.
        send(0, 19'h00280, 19'd0, 10'd103, 10'd100, 9'd100, 9'd100, 0, 1);
        send(0, 19'h00280, 19'd0, 10'd104, 10'd100, 9'd100, 9'd100, 0, 0);
        send(0, 19'h7FD80, 19'd0, 10'd98,  10'd100, 9'd100, 9'd100, 0, 1);
        send(0, 19'h7FD80, 19'd0, 10'd97,  10'd100, 9'd100, 9'd100, 0, 0);
        // Saturation to +/-255.
        send(0, 19'h3FF00, 19'd0, 10'd255, 10'd0, 9'd0, 9'd0, 0, 1);
        send(0, 19'h3FF00, 19'd0, 10'd256, 10'd0, 9'd0, 9'd0, 0, 0);
        send(0, 19'h40100, 19'd0, 10'd45,  10'd0, 9'd300, 9'd0, 0, 1);
        send(0, 19'h40100, 19'd0, 10'd44,  10'd0, 9'd300, 9'd0, 0, 0);
        // Half-unit boundaries around zero radius, square at (51,60) vs ref (50,60).
        send(0, 19'h0007F, 19'd0, 10'd51, 10'd60, 9'd50, 9'd60, 1, 0);
        send(0, 19'h00080, 19'd0, 10'd51, 10'd60, 9'd50, 9'd60, 1, 1);
        send(0, 19'h7FF80, 19'd0, 10'd51, 10'd60, 9'd50, 9'd60, 1, 0);
        send(0, 19'h7FF7F, 19'd0, 10'd51, 10'd60, 9'd50, 9'd60, 1, 1);
        // Zero radius: only the reference pixel itself hits.
        send(0, 19'd0, 19'd0, 10'd50, 10'd60, 9'd50, 9'd60, 1, 1);
        send(0, 19'd0, 19'd0, 10'd51, 10'd60, 9'd50, 9'd60, 1, 0);
        send(0, 19'd0, 19'd0, 10'd50, 10'd60, 9'd50, 9'd60, 0, 1);
        send(0, 19'd0, 19'd0, 10'd50, 10'd61, 9'd50, 9'd60, 0, 0);
        // Alternating bubbles at full rate; bubble slots carry hit-producing data.
        for (int i = 0; i < 8; i++)
            send(i[0], 19'd2560, 19'd0, 10'd106, 10'd108, 9'd100, 9'd100, 0, 1);
        drain();

        // Reset with pixels in flight: everything still in the pipe is discarded.
        for (int i = 0; i < 3; i++)
            send(0, 19'd2560, 19'd0, 10'd100, 10'd100, 9'd100, 9'd100, 0, 1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        sb.delete();
        #1;
        check("midreset_bubble", int'(out_bubble), 1);
        check("midreset_hit", int'(out_hit), 0);
        check("midreset_color", int'(out_color), int'(BG));
        @(negedge clk);
        reset = 1'b1;
        drive(0, 19'd2560, 19'd0, 10'd101, 10'd102, 9'd100, 9'd100, 0, 1);
        @(posedge clk);
        #1;
        check("post_reset_bubble_1", int'(out_bubble), 1);
        @(negedge clk);
        in_bubble = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_bubble_2", int'(out_bubble), 1);
        drain();

`ifdef CORDIC_RESOLVE_STATS_EN
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("stats_reset", int'(hit_count), 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++)
            send(0, 19'd2560, 19'd0, 10'd100, 10'd100, 9'd100, 9'd100, 0, 1);
        drain();
        check("stats_five", int'(hit_count), 5);
        send(0, 19'd2560, 19'd0, 10'd0, 10'd0, 9'd0, 9'd0, 0, 1);
        drain();
        check("stats_origin_restart", int'(hit_count), 1);
        for (int i = 0; i < 70000; i++)
            send(0, 19'd2560, 19'd0, 10'd100, 10'd100, 9'd100, 9'd100, 0, 1);
        drain();
        check("stats_saturate", int'(hit_count), 65535);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/stage_cordic_resolve.md
STAGE_CORDIC_RESOLVE -- requirements
Module: stage_cordic_resolve

Interface
REQ-001 SHALL have parameter BG_COLOR, default 9'h000: color emitted for pixels outside the shape.
REQ-002 SHALL have port clk, input, 1: rising-edge clock.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port cord_x, input, 19, signed Q11.8: rotated vertex offset X from the final CORDIC stage.
REQ-005 SHALL have port cord_y, input, 19, signed Q11.8: rotated vertex offset Y.
REQ-006 SHALL have port in_bubble, input, 1: 1 = empty pipeline slot.
REQ-007 SHALL have ports in_color [8:0], in_pixel_x [9:0], in_pixel_y [9:0], in_ref_point_x [8:0], in_ref_point_y [8:0] and in_form [0:0], all inputs, as pixel sideband (form 0 = circle, 1 = square).
REQ-008 SHALL have port out_bubble, output, 1: 1 = empty slot.
REQ-009 SHALL have ports out_color [8:0], out_pixel_x [9:0], out_pixel_y [9:0] and out_hit [0:0], all outputs: resolved pixel.
REQ-010 SHALL have port hit_count, output, 16: per-frame hit count (present only with CORDIC_RESOLVE_STATS_EN).

Function
REQ-011 SHALL be a 3-stage pipeline (S1, S2, S3): inputs sampled on edge N appear on outputs after edge N+2, one pixel per cycle, no stalls.
REQ-012 S1 SHALL round cord_x/cord_y to integers dx/dy: add 0x80, then >>>8 (round half up), and saturate to [-255,+255].
REQ-013 S1 SHALL form px = pixel_x - ref_point_x and py = pixel_y - ref_point_y as 11-bit signed values, with no overflow possible.
REQ-014 S2 SHALL register r2 = dx*dx + dy*dy (18-bit unsigned).
REQ-015 S2 SHALL register c2 = px*px + py*py (22-bit unsigned).
REQ-016 S2 SHALL register dot = px*dx + py*dy and crs = py*dx - px*dy (each 21-bit signed).
REQ-017 S3 SHALL set hit as follows: for form 0, hit = (c2 <= r2); for form 1, hit = (|dot| <= r2) AND (|crs| <= r2); all comparisons are inclusive.
REQ-018 S3 SHALL drive out_color = hit ? color : BG_COLOR, and out_hit = hit.
REQ-019 When the slot is a bubble, S3 SHALL force out_hit = 0 and out_color = BG_COLOR; pixel outputs still pass through.
REQ-020 Sideband signals (color, pixel_x/y, form, bubble) SHALL be delayed in lockstep with the arithmetic.
REQ-021 When dx = dy = 0, the result SHALL be a hit only if px = py = 0 (both forms).

Reset
REQ-022 Asserting reset SHALL immediately set out_bubble = 1 and the internal S1/S2 bubble flags = 1.
REQ-023 Asserting reset SHALL immediately set out_hit = 0, out_color = BG_COLOR and hit_count = 0.
REQ-024 Data registers other than those in REQ-022 and REQ-023 SHALL NOT be reset.
REQ-025 After reset releases, the first valid output SHALL appear 3 edges after the first non-bubble input is sampled.
REQ-026 Reset asserted mid-stream SHALL discard all in-flight pixels.

Configuration
REQ-027 With CORDIC_RESOLVE_STATS_EN defined, hit_count SHALL increment by 1 at each S3 output with out_hit = 1 and out_bubble = 0.
REQ-028 With CORDIC_RESOLVE_STATS_EN defined, hit_count SHALL saturate at 16'hFFFF.
REQ-029 With CORDIC_RESOLVE_STATS_EN defined, hit_count SHALL clear to 0 when an S3 output is non-bubble with pixel (0,0); that pixel's own hit then counts as 1.
REQ-030 Without CORDIC_RESOLVE_STATS_EN, the hit_count port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Circle: cord=(2560,0), ref=(100,100), form 0 -> pixel (106,108) gives hit=1, color passes; pixel (107,108) gives hit=0, out_color=BG_COLOR.
REQ-032 Square: cord=(2560,0), ref=(100,100), form 1 -> pixel (110,90) gives hit=1; pixel (111,100) gives hit=0; pixel (90,110) gives hit=1.
REQ-033 Rounding/saturation: cord_x=0x00280 gives dx=3; cord_x=-640 gives dx=-2; cord_x=0x3FF00 (+1023) gives dx=255.
REQ-034 Latency/bubble: alternating in_bubble 0/1 at full rate -> outputs follow with exact 3-edge latency; bubble slots show out_hit=0 and out_color=BG_COLOR.
REQ-035 Reset mid-stream: assert reset with 3 pixels in flight -> out_bubble=1 immediately and for 2 edges after release, and no stale hit appears.
REQ-036 Stats (CORDIC_RESOLVE_STATS_EN): 5 hits then pixel (0,0) as a hit -> hit_count=5, then 1; 70000 hits -> hit_count=16'hFFFF.
